// File: rtl/stream_mode_sched.sv
// Run-time stream selector: debounced button mode request, frame-boundary mode switching,
// and draining of unselected streams. Optional statistics ports under STREAM_SCHED_STATS_EN.
module stream_mode_sched #(
  parameter int FrameLenRaw    = 76800,
  parameter int FrameLenProc   = 75684,
  parameter int DebounceCycles = 250000,
  parameter int DataWidth      = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [2:0]             button_i,
  input  logic [4*DataWidth-1:0] src_data_i,
  input  logic [3:0]             src_valid_i,
  output logic [3:0]             src_ready_o,
  output logic [DataWidth-1:0]   data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [1:0]             mode_o,
  output logic                   align_o,
  output logic                   frame_done_o
`ifdef STREAM_SCHED_STATS_EN
  ,
  output logic [15:0]            frames_o,
  output logic [15:0]            drop_o
`endif
);

  localparam int MaxLen = (FrameLenRaw > FrameLenProc) ? FrameLenRaw : FrameLenProc;
  localparam int CntW   = $clog2(MaxLen);
  localparam int DbW    = $clog2(DebounceCycles);

  localparam logic [CntW-1:0] RawLast  = CntW'(FrameLenRaw - 1);
  localparam logic [CntW-1:0] ProcLast = CntW'(FrameLenProc - 1);
  localparam logic [DbW-1:0]  DbLast   = DbW'(DebounceCycles - 1);

  typedef enum logic [0:0] {
    ST_ALIGN = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  function automatic logic [1:0] decode_buttons(input logic [2:0] b);
    logic [1:0] m;
    case (b)
      3'b001:  m = 2'd0;
      3'b010:  m = 2'd1;
      3'b100:  m = 2'd2;
      default: m = 2'd3;
    endcase
    return m;
  endfunction

  function automatic logic [CntW-1:0] last_beat(input logic [1:0] m);
    return (m == 2'd0) ? RawLast : ProcLast;
  endfunction

  logic [2:0]           btn_meta_r;
  logic [2:0]           btn_sync_r;
  logic [2:0]           btn_hold_r;
  logic [DbW-1:0]       db_cnt_r;
  logic [1:0]           pending_r;
  logic [CntW-1:0]      src_cnt_r [4];
  state_t               state_r;
  logic [1:0]           mode_r;
  logic [CntW-1:0]      out_cnt_r;

  logic                 sel_valid_s;
  logic [DataWidth-1:0] sel_data_s;
  logic                 out_hs_s;
  logic                 frame_end_s;
  logic [3:0]           src_hs_s;
  logic                 align_exit_s;

  // Two-flop synchronizer for the asynchronous board buttons.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      btn_meta_r <= 3'b000;
      btn_sync_r <= 3'b000;
    end else begin
      btn_meta_r <= button_i;
      btn_sync_r <= btn_meta_r;
    end
  end

  // Debounce: restart on any change; once stable long enough, keep refreshing the request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      btn_hold_r <= 3'b000;
      db_cnt_r   <= {DbW{1'b0}};
      pending_r  <= 2'd3;
    end else if (btn_sync_r != btn_hold_r) begin
      btn_hold_r <= btn_sync_r;
      db_cnt_r   <= {DbW{1'b0}};
    end else if (db_cnt_r == DbLast) begin
      pending_r  <= decode_buttons(btn_hold_r);
    end else begin
      db_cnt_r   <= db_cnt_r + 1'b1;
    end
  end

  // Output mux: selected source passes straight through while running; ALIGN drains everything.
  always_comb begin
    sel_valid_s = src_valid_i[mode_r];
    sel_data_s  = src_data_i[DataWidth*int'(mode_r) +: DataWidth];
    valid_o     = 1'b0;
    data_o      = {DataWidth{1'b0}};
    src_ready_o = 4'b1111;
    if (state_r == ST_RUN) begin
      valid_o             = sel_valid_s;
      data_o              = sel_data_s;
      src_ready_o[mode_r] = ready_i;
    end else begin
      valid_o     = 1'b0;
      data_o      = {DataWidth{1'b0}};
      src_ready_o = 4'b1111;
    end
  end

  // Handshake decode shared by the counters and the FSM.
  always_comb begin
    out_hs_s     = valid_o & ready_i;
    frame_end_s  = out_hs_s & (out_cnt_r == last_beat(mode_r));
    src_hs_s     = src_valid_i & src_ready_o;
    align_exit_s = (src_cnt_r[mode_r] == {CntW{1'b0}}) & ~src_hs_s[mode_r];
  end

  assign frame_done_o = frame_end_s;
  assign align_o      = (state_r == ST_ALIGN);
  assign mode_o       = mode_r;

  // Frame position of every source, tracked whether selected or not.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 4; i++) begin
        src_cnt_r[i] <= {CntW{1'b0}};
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (src_hs_s[i]) begin
          if (src_cnt_r[i] == ((i == 0) ? RawLast : ProcLast)) begin
            src_cnt_r[i] <= {CntW{1'b0}};
          end else begin
            src_cnt_r[i] <= src_cnt_r[i] + 1'b1;
          end
        end
      end
    end
  end

  // Scheduler FSM: mode only changes at a frame end, then waits for the new source's frame start.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r   <= ST_ALIGN;
      mode_r    <= 2'd3;
      out_cnt_r <= {CntW{1'b0}};
    end else begin
      case (state_r)
        ST_ALIGN: begin
          if (align_exit_s) begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (frame_end_s) begin
            out_cnt_r <= {CntW{1'b0}};
            if (pending_r != mode_r) begin
              mode_r  <= pending_r;
              state_r <= ST_ALIGN;
            end
          end else if (out_hs_s) begin
            out_cnt_r <= out_cnt_r + 1'b1;
          end
        end
        default: begin
          state_r   <= ST_ALIGN;
          out_cnt_r <= {CntW{1'b0}};
        end
      endcase
    end
  end

`ifdef STREAM_SCHED_STATS_EN
  logic [15:0] frames_r;
  logic [15:0] drop_r;

  // Frame counter wraps; drop counter saturates on beats of the selected source drained in ALIGN.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      frames_r <= 16'd0;
      drop_r   <= 16'd0;
    end else begin
      if (frame_end_s) begin
        frames_r <= frames_r + 16'd1;
      end
      if ((state_r == ST_ALIGN) && src_hs_s[mode_r] && (drop_r != 16'hFFFF)) begin
        drop_r <= drop_r + 16'd1;
      end
    end
  end

  assign frames_o = frames_r;
  assign drop_o   = drop_r;
`endif

endmodule

// File: tb/tb_stream_mode_sched.sv
// Self-checking bench for stream_mode_sched with shortened frames and debounce time.
module tb_stream_mode_sched;

  localparam int FLR = 12;
  localparam int FLP = 9;
  localparam int DC  = 6;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [2:0] button;
  logic [3:0] src_data;
  logic [3:0] src_valid;
  logic [3:0] src_ready;
  logic       data_o;
  logic       valid_o;
  logic       ready_i;
  logic [1:0] mode_o;
  logic       align_o;
  logic       frame_done;
`ifdef STREAM_SCHED_STATS_EN
  logic [15:0] frames;
  logic [15:0] drop;
`endif

  always #5 clk = ~clk;

  stream_mode_sched #(
    .FrameLenRaw(FLR), .FrameLenProc(FLP), .DebounceCycles(DC), .DataWidth(1)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .button_i(button), .src_data_i(src_data),
    .src_valid_i(src_valid), .src_ready_o(src_ready), .data_o(data_o),
    .valid_o(valid_o), .ready_i(ready_i), .mode_o(mode_o), .align_o(align_o),
    .frame_done_o(frame_done)
`ifdef STREAM_SCHED_STATS_EN
    , .frames_o(frames), .drop_o(drop)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int   m_mode, m_beats, m_pend, b_last, stab;
  bit   m_align;
  // Source state
  int   pos [4];
  bit   held [4];
  int   cyc;
  // Observations
  int   fr_beats, last_beats, done_cnt;
  logic first_data;
  bit   watch0, saw0;
  logic e_valid, e_done;
  logic [3:0] e_ready;

  function automatic int flen(input int i);
    return (i == 0) ? FLR : FLP;
  endfunction

  function automatic logic src_bit(input int i, input int b);
    return (((b * (2 * i + 3) + i) % 3) == 0);
  endfunction

  function automatic int decode(input int b);
    case (b)
      1:       return 0;
      2:       return 1;
      4:       return 2;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    m_mode = 3; m_align = 1'b1; m_beats = 0; m_pend = 3; b_last = 0; stab = 0;
    for (int i = 0; i < 4; i++) begin
      pos[i] = 0; held[i] = 1'b0;
    end
    fr_beats = 0;
  endtask

  // Sources: AXIS producers with a gap every sixth cycle, holding data while stalled.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (!held[i]) begin
        src_valid[i] = (((cyc + i) % 6) != 0);
        src_data[i]  = src_bit(i, pos[i]);
      end
    end
  endtask

  task automatic wait_done(input string nm, input int budget);
    int start;
    int k;
    start = done_cnt;
    k = 0;
    while (done_cnt == start && k < budget) begin
      tick();
      k++;
    end
    chk({nm, "_done_seen"}, (done_cnt != start), 1);
  endtask

  task automatic wait_beats(input string nm, input int n, input int budget);
    int k;
    k = 0;
    while (fr_beats < n && k < budget) begin
      tick();
      k++;
    end
    chk({nm, "_reached"}, (fr_beats >= n), 1);
  endtask

  // Compare process: DUT outputs against the model every active cycle, then advance the model.
  always @(negedge clk) begin
    if (rst_i === 1'b1) begin
      e_valid = !m_align && src_valid[m_mode];
      e_ready = 4'hF;
      if (!m_align) e_ready[m_mode] = ready_i;
      e_done  = e_valid && ready_i && (m_beats == flen(m_mode) - 1);
      chk("mode", mode_o, m_mode);
      chk("align", align_o, m_align);
      chk("valid", valid_o, e_valid);
      chk("src_ready", src_ready, e_ready);
      chk("frame_done", frame_done, e_done);
      if (e_valid) chk("data", data_o, src_bit(m_mode, pos[m_mode]));
      if (e_valid && ready_i) chk("frame_pos", pos[m_mode], m_beats);

      if (valid_o && ready_i) begin
        if (fr_beats == 0) first_data = data_o;
        fr_beats++;
        if (frame_done) begin
          last_beats = fr_beats;
          fr_beats = 0;
          done_cnt++;
        end
      end
      if (watch0 && mode_o == 2'd0) saw0 = 1'b1;

      if (m_align) begin
        if (pos[m_mode] == 0 && !src_valid[m_mode]) m_align = 1'b0;
      end else if (e_valid && ready_i) begin
        if (m_beats == flen(m_mode) - 1) begin
          m_beats = 0;
          if (m_pend != m_mode) begin
            m_mode  = m_pend;
            m_align = 1'b1;
          end
        end else begin
          m_beats++;
        end
      end

      if (int'(button) == b_last) stab++;
      else begin
        b_last = int'(button);
        stab = 1;
      end
      if (stab >= DC + 3) m_pend = decode(b_last);

      for (int i = 0; i < 4; i++) begin
        if (src_valid[i] && src_ready[i]) pos[i] = (pos[i] + 1) % flen(i);
        held[i] = src_valid[i] && !src_ready[i];
      end
    end
  end

  initial begin
    logic pv;
    logic pd;
    rst_i = 1'b1; button = 3'b000; ready_i = 1'b1; src_valid = 4'h0; src_data = 4'h0;
    cyc = 0; done_cnt = 0; last_beats = 0; first_data = 1'b0; watch0 = 1'b0; saw0 = 1'b0;
    reset_model();
    #1 rst_i = 1'b0;
    #1;
    chk("rst_mode", mode_o, 3);
    chk("rst_align", align_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_ready", src_ready, 4'hF);
    chk("rst_done", frame_done, 0);
`ifdef STREAM_SCHED_STATS_EN
    chk("rst_frames", frames, 0);
    chk("rst_drop", drop, 0);
`endif
    tick(); tick(); tick();
    rst_i = 1'b1;

    // First mag frame after reset
    wait_done("first_frame", 300);
    chk("first_beats", last_beats, 9);
    chk("first_data", first_data, 1'b1);
    chk("first_mode", mode_o, 3);

    // Press gx mid-frame while the framer stalls
    wait_beats("gx_press", 2, 100);
    button = 3'b010;
    ready_i = 1'b0;
    pv = 1'b0;
    pd = 1'b0;
    for (int k = 0; k < DC + 10; k++) begin
      tick();
      #1;
      chk("stall_sel_ready", src_ready[3], 1'b0);
      chk("stall_other_ready", src_ready[2:0], 3'b111);
      chk("stall_mode", mode_o, 3);
      if (pv) begin
        chk("stall_valid", valid_o, 1'b1);
        chk("stall_data", data_o, pd);
      end
      pv = valid_o;
      pd = data_o;
    end
    ready_i = 1'b1;
    wait_done("gx_switch", 200);
    chk("gx_mode", mode_o, 1);
    chk("gx_align", align_o, 1);
    wait_done("gx_frame", 300);
    chk("gx_beats", last_beats, 9);
    chk("gx_mode_after", mode_o, 1);

    // Bouncing buttons, then steady gy
    watch0 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      button = ((k % 2) == 1) ? 3'b100 : 3'b001;
      repeat (3) tick();
    end
    button = 3'b100;
    repeat (2 * DC + 6) tick();
    wait_done("bounce_frame", 300);
    watch0 = 1'b0;
    chk("bounce_no_raw", saw0, 0);
    chk("bounce_mode", mode_o, 2);

    // Switch to raw: full-length raw frame
    button = 3'b001;
    repeat (2 * DC + 6) tick();
    wait_done("raw_switch", 300);
    chk("raw_mode", mode_o, 0);
    wait_done("raw_frame", 300);
    chk("raw_beats", last_beats, 12);
    chk("raw_mode_after", mode_o, 0);

    // Reset mid-frame
    wait_beats("raw_mid", 5, 100);
    tick();
    rst_i = 1'b0;
    #1;
    chk("mid_rst_mode", mode_o, 3);
    chk("mid_rst_align", align_o, 1);
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_ready", src_ready, 4'hF);
    chk("mid_rst_done", frame_done, 0);
`ifdef STREAM_SCHED_STATS_EN
    chk("mid_rst_frames", frames, 0);
`endif
    reset_model();
    tick(); tick(); tick();
    rst_i = 1'b1;
    wait_done("post_reset", 300);
    chk("post_reset_beats", last_beats, 9);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stream_mode_sched.md
Name: stream_mode_sched

Overview:
- Run-time controller that selects which processed stream feeds the output framer: raw deframed pixels, Gx, Gy or magnitude.
- Debounces the board buttons into a mode request and applies mode changes only on frame boundaries, so the framer never emits a mixed or truncated frame.
- Drains unselected streams so the shared conv/mag pipeline never stalls.
- Sits between the deframer/conv2d/mag outputs and the framer input.

Parameters:
- FrameLenRaw, 76800, raw-stream beats per frame (WidthIn*HeightIn).
- FrameLenProc, 75684, Gx/Gy/mag beats per frame (WidthOut*HeightOut).
- DebounceCycles, 250000, cycles a synchronized button pattern must hold unchanged before it is accepted (10 ms at 25 MHz).
- DataWidth, 1, pixel width per beat.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; asynchronous assert, active-low.
- button_i  in  3  raw board buttons [3:1].
- src_data_i  in  4*DataWidth  source data; index 0=raw, 1=gx, 2=gy, 3=mag.
- src_valid_i  in  4  per-source valid.
- src_ready_o  out  4  per-source ready.
- data_o  out  DataWidth  to framer.
- valid_o  out  1  to framer.
- ready_i  in  1  framer ready.
- mode_o  out  2  active mode (0 raw, 1 gx, 2 gy, 3 mag).
- align_o  out  1  high while in ALIGN.
- frame_done_o  out  1  one-cycle pulse on the last output beat of a frame.

Behaviour:
- Reset values: mode_o=3 (mag), pending=3, state=ALIGN, all counters 0, valid_o=0, frame_done_o=0, align_o=1, src_ready_o=4'b1111.
- Buttons: 2-flop synchronizer, then debounce counter.
  - Counter restarts on any change of the synchronized value.
  - When the count reaches DebounceCycles-1, the value is decoded into pending: 3'b001→0, 3'b010→1, 3'b100→2, else→3.
  - Pending is updated continuously; the last value wins.
- Per-source beat counters src_cnt[i]:
  - Increment on src_valid_i[i] & src_ready_o[i].
  - Wrap to 0 after FrameLenRaw-1 (i=0) or FrameLenProc-1 (i=1..3).
  - They always track each source's frame position, selected or not.
- State RUN:
  - data_o, valid_o and src_ready_o[mode] are combinational passthrough of the selected source (zero latency).
  - All other src_ready_o = 1, so unselected beats are drained and discarded.
  - out_cnt increments on valid_o & ready_i.
  - On the handshake where out_cnt = FrameLen(mode)-1: frame_done_o pulses and out_cnt goes to 0.
  - Same cycle: if pending != mode, then mode <= pending and the state goes to ALIGN; otherwise stay in RUN.
- State ALIGN:
  - valid_o=0; all src_ready_o=1.
  - When src_cnt[mode]==0 and no handshake on that source is occurring this cycle, go to RUN next cycle.
  - A handshake in the same cycle would advance the count off 0, so it defers the transition.
  - Mode is frozen in ALIGN; a pending change waits for the next frame end.
- A button change mid-frame never alters mode_o before frame_done_o.
- ready_i low holds the selected source stalled. valid_o is never dropped once asserted in RUN without a handshake, provided the source obeys AXIS.
- Reset mid-frame: all state returns to reset values immediately. The scheduler realigns via ALIGN using fresh src_cnt, so the upstream pipeline must be reset together with it.
- Counter widths: $clog2(max frame len).

Optional Feature:
- Macro: STREAM_SCHED_STATS_EN.
- Defined:
  - Adds output frames_o[15:0], counting frame_done_o pulses and wrapping at 65535→0.
  - Adds output drop_o[15:0], counting saturating beats drained from the selected source while in ALIGN.
  - Both reset to 0.
- Undefined: neither port exists; no extra logic.

Test Plan:
- Reset with all sources valid and button_i=0 → mode_o=3, align_o=1. Enters RUN once src_cnt[3]=0; the first framer beat equals mag data; frame_done_o pulses after 75684 accepted beats.
- Press button_i=3'b010 stable for DebounceCycles at beat 1000 of a mag frame → mode_o stays 3 until frame_done_o, then 1. ALIGN lasts until the gx counter wraps; the next frame contains only gx data.
- Button bounce toggling every 1000 cycles for 10 ms, then steady 3'b100 → pending takes only the final value (2); no intermediate mode is ever applied.
- Switch mag→raw (button 3'b001) → the output frame after the switch carries exactly 76800 beats, then frame_done_o.
- Framer ready_i held low for 50 cycles mid-frame → selected source src_ready_o=0 and data_o/valid_o stable; unselected readies stay 1; out_cnt is unchanged.
- Assert rst_i low at beat 500 for 3 cycles → outputs return to reset values asynchronously. After release, the block re-enters ALIGN and resynchronizes; with STREAM_SCHED_STATS_EN, frames_o=0.
